// File: rtl/avalon_pkg.sv
// Shared Avalon-MM widths, the read-command record and engine state type.
// Imported by the responder, its command FIFO and its bus interface.
package avalon_pkg;

   localparam int AVM_DATA_W  = 32;
   localparam int AVM_BE_W    = 4;
   localparam int AVM_BURST_W = 3;
   localparam int AVM_WADDR_W = 30;

   typedef struct packed {
      logic [AVM_WADDR_W-1:0] word_addr;
      logic [AVM_BURST_W-1:0] burst;
   } rd_cmd_t;

   typedef enum logic {
      ENG_IDLE,
      ENG_BUSY
   } eng_state_t;

   // A zero burst count still means one beat.
   function automatic logic [AVM_BURST_W-1:0] norm_burst(
      input logic [AVM_BURST_W-1:0] b
   );
      return (b == '0) ? AVM_BURST_W'(1) : b;
   endfunction

endpackage

// File: rtl/avalon_ram_responder_if.sv
// Avalon-MM bus bundle between the CPU-side master and the RAM responder.
// The master drives command fields; the slave drives stall and read beats.
interface avalon_ram_responder_if;
   import avalon_pkg::*;

   logic [31:0]            avs_address;
   logic [AVM_DATA_W-1:0]  avs_writedata;
   logic [AVM_BE_W-1:0]    avs_byteenable;
   logic [AVM_BURST_W-1:0] avs_burstcount;
   logic                   avs_write;
   logic                   avs_read;
   logic                   avs_waitrequest;
   logic                   avs_readdatavalid;
   logic [AVM_DATA_W-1:0]  avs_readdata;

   modport master (
      output avs_address,
      output avs_writedata,
      output avs_byteenable,
      output avs_burstcount,
      output avs_write,
      output avs_read,
      input  avs_waitrequest,
      input  avs_readdatavalid,
      input  avs_readdata
   );

   modport slave (
      input  avs_address,
      input  avs_writedata,
      input  avs_byteenable,
      input  avs_burstcount,
      input  avs_write,
      input  avs_read,
      output avs_waitrequest,
      output avs_readdatavalid,
      output avs_readdata
   );

endinterface

// File: rtl/avalon_ram_responder_cmd_fifo.sv
// Show-ahead FIFO of pending read commands with occupancy count.
// Push and pop in the same cycle are allowed, including when full.
module avs_cmd_fifo
   import avalon_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  rd_cmd_t                din,
   input  logic                   pop,
   output rd_cmd_t                dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   rd_cmd_t         mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/avalon_ram_responder.sv
// Avalon-MM RAM responder: byte-lane writes, queued gapless burst reads.
// Define AVS_WAIT_INJECT_EN to add LFSR-driven random waitrequest stalls.
module avalon_ram_responder
   import avalon_pkg::*;
#(
   parameter int    ADDR_WIDTH = 12,
   parameter int    CMD_DEPTH  = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic clk,
   input  logic rst_n,
   avalon_ram_responder_if.slave avs
);

   localparam int CW = $clog2(CMD_DEPTH);

   logic [AVM_DATA_W-1:0] ram [2**ADDR_WIDTH];

   eng_state_t             eng_st;
   eng_state_t             eng_nxt;
   logic [ADDR_WIDTH-1:0]  eng_addr;
   logic [AVM_BURST_W-1:0] eng_rem;
   logic                   last_beat;
   logic                   beat;

   rd_cmd_t                q_din;
   rd_cmd_t                q_head;
   logic                   q_push;
   logic                   q_pop;
   logic [CW:0]            q_count;
   logic                   q_empty;
   logic                   q_full;

   logic                   inj_stall;
   logic                   wr_hazard;
   logic                   rd_hazard;
   logic                   wr_acc;
   logic                   rd_acc;
   logic [ADDR_WIDTH-1:0]  wr_addr;

   logic                   rd_valid;
   logic [AVM_DATA_W-1:0]  rd_data;
   logic                   unused;

`ifdef AVS_WAIT_INJECT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0],
                  lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign inj_stall = (lfsr[1:0] == 2'b00);
`else
   assign inj_stall = 1'b0;
`endif

   // Writes wait for every outstanding read so they never overtake one.
   assign wr_hazard = (eng_st == ENG_BUSY) | ~q_empty;
   assign rd_hazard = q_full | avs.avs_write;

   assign avs.avs_waitrequest = (avs.avs_write & wr_hazard)
                              | (avs.avs_read & rd_hazard)
                              | inj_stall;

   assign wr_acc = avs.avs_write & ~wr_hazard & ~inj_stall;
   assign rd_acc = avs.avs_read & ~rd_hazard & ~inj_stall;

   assign wr_addr         = avs.avs_address[ADDR_WIDTH+1:2];
   assign q_push          = rd_acc;
   assign q_din.word_addr = avs.avs_address[31:2];
   assign q_din.burst     = norm_burst(avs.avs_burstcount);

   avs_cmd_fifo #(
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push),
      .din   (q_din),
      .pop   (q_pop),
      .dout  (q_head),
      .count (q_count),
      .empty (q_empty),
      .full  (q_full)
   );

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < AVM_BE_W; i++) begin
            if (avs.avs_byteenable[i]) begin
               ram[wr_addr][8*i +: 8] <= avs.avs_writedata[8*i +: 8];
            end
         end
      end
   end

   assign last_beat = (eng_rem == AVM_BURST_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_st <= ENG_IDLE;
      end else begin
         eng_st <= eng_nxt;
      end
   end

   always_comb begin
      eng_nxt = eng_st;
      unique case (eng_st)
         ENG_IDLE: if (!q_empty) eng_nxt = ENG_BUSY;
         ENG_BUSY: if (last_beat && q_empty) eng_nxt = ENG_IDLE;
         default:  eng_nxt = ENG_IDLE;
      endcase
   end

   // Popping on the last beat chains the next burst with no idle cycle.
   always_comb begin
      q_pop = 1'b0;
      beat  = 1'b0;
      unique case (eng_st)
         ENG_IDLE: q_pop = ~q_empty;
         ENG_BUSY: begin
            beat  = 1'b1;
            q_pop = last_beat & ~q_empty;
         end
         default: begin
            q_pop = 1'b0;
            beat  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_addr <= '0;
         eng_rem  <= '0;
      end else if (q_pop) begin
         eng_addr <= q_head.word_addr[ADDR_WIDTH-1:0];
         eng_rem  <= q_head.burst;
      end else if (beat) begin
         eng_addr <= eng_addr + ADDR_WIDTH'(1);
         eng_rem  <= eng_rem - AVM_BURST_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= beat;
         if (beat) begin
            rd_data <= ram[eng_addr];
         end
      end
   end

   assign avs.avs_readdatavalid = rd_valid;
   assign avs.avs_readdata      = rd_data;

   assign unused = ^{avs.avs_address[1:0],
                     q_head.word_addr[AVM_WADDR_W-1:ADDR_WIDTH],
                     q_count};

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Scoreboard bench for avalon_ram_responder with directed vectors.
// Expected beats are queued at issue and checked by a beat monitor.
module tb_avalon_ram_responder;

   localparam int AW = 12;
   localparam int CD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   avalon_ram_responder_if bus ();

   avalon_ram_responder #(
      .ADDR_WIDTH (AW),
      .CMD_DEPTH  (CD),
      .INIT_FILE  ("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .avs   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.avs_readdatavalid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none",
                     bus.avs_readdata);
         end else begin
            check("beat", bus.avs_readdata, exp_q.pop_front());
         end
      end
   end

   task automatic do_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0] be,
                           output int stalls);
      bus.avs_address    = a;
      bus.avs_writedata  = d;
      bus.avs_byteenable = be;
      bus.avs_write      = 1'b1;
      stalls = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.avs_waitrequest) begin
            @(posedge clk);
            #1;
            bus.avs_write = 1'b0;
            return;
         end
         stalls++;
      end
      check("write_timeout", 32'd1, 32'd0);
      bus.avs_write = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a,
                          input logic [2:0] bc,
                          output int stalls);
      bus.avs_address    = a;
      bus.avs_burstcount = bc;
      bus.avs_read       = 1'b1;
      stalls = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.avs_waitrequest) begin
            @(posedge clk);
            #1;
            bus.avs_read = 1'b0;
            return;
         end
         stalls++;
      end
      check("read_timeout", 32'd1, 32'd0);
      bus.avs_read = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      int s;
      do_write(a, d, 4'hF, s);
   endtask

   task automatic check_run(input string name, input int n);
      int k;
      k = 0;
      while (!bus.avs_readdatavalid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_start"}, 32'(bus.avs_readdatavalid), 32'd1);
      for (int i = 1; i < n; i++) begin
         @(posedge clk);
         #1;
         check({name, "_gapless"}, 32'(bus.avs_readdatavalid), 32'd1);
      end
      @(posedge clk);
      #1;
      check({name, "_end"}, 32'(bus.avs_readdatavalid), 32'd0);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      int tot;
      bus.avs_address    = '0;
      bus.avs_writedata  = '0;
      bus.avs_byteenable = '0;
      bus.avs_burstcount = '0;
      bus.avs_write      = 1'b0;
      bus.avs_read       = 1'b0;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.avs_readdatavalid), 32'd0);
      check("rst_data", bus.avs_readdata, 32'd0);
      check("rst_wait", 32'(bus.avs_waitrequest), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      wr(32'h10, 32'hDEADBEEF);
      exp_q.push_back(32'hDEADBEEF);
      do_read(32'h10, 3'd1, s);
      check("lat_t0", 32'(bus.avs_readdatavalid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_t1", 32'(bus.avs_readdatavalid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_t2", 32'(bus.avs_readdatavalid), 32'd1);
      drain("b1");
      check("hold_data", bus.avs_readdata, 32'hDEADBEEF);

      do_write(32'h10, 32'h11223344, 4'b0101, s);
      exp_q.push_back(32'hDE22BE44);
      do_read(32'h10, 3'd1, s);
      drain("be");

      for (int i = 0; i < 4; i++) begin
         wr(32'(4 * i), 32'hA0 + 32'(i));
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'hA0 + 32'(i));
      end
      do_read(32'h0, 3'd4, s);
      check_run("burst4", 4);
      drain("burst4");

      wr(32'h3FFC, 32'h000000FF);
      exp_q.push_back(32'h000000FF);
      exp_q.push_back(32'hA0);
      exp_q.push_back(32'hA1);
      exp_q.push_back(32'hA2);
      do_read(32'h3FFC, 3'd4, s);
      check_run("wrap", 4);
      drain("wrap");

      wr(32'h14, 32'hC5);
      wr(32'h18, 32'hC6);
      wr(32'h1C, 32'hC7);
      tot = 0;
      for (int r = 0; r < CD + 2; r++) begin
         if (r % 2 == 0) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
            do_read(32'h0, 3'd4, s);
         end else begin
            exp_q.push_back(32'hDE22BE44);
            exp_q.push_back(32'hC5);
            exp_q.push_back(32'hC6);
            exp_q.push_back(32'hC7);
            do_read(32'h10, 3'd4, s);
         end
         tot += s;
      end
      check("full_stalled", 32'(tot > 0), 32'd1);
      drain("b2b");

      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
      do_read(32'h0, 3'd4, s);
      bus.avs_address    = 32'h4;
      bus.avs_writedata  = 32'h55;
      bus.avs_byteenable = 4'hF;
      bus.avs_write      = 1'b1;
      #1;
      check("wr_stall_busy", 32'(bus.avs_waitrequest), 32'd1);
      do_write(32'h4, 32'h55, 4'hF, s);
      check("wr_stall_cycles", 32'(s), 32'd5);
      check("wr_after_reads", 32'(exp_q.size()), 32'd0);
      exp_q.push_back(32'h55);
      do_read(32'h4, 3'd1, s);
      drain("wr_land");

      exp_q.push_back(32'hDE22BE44);
      do_read(32'h10, 3'd0, s);
      check_run("burst0", 1);
      drain("burst0");

      exp_q.push_back(32'hDE22BE44);
      exp_q.push_back(32'hC5);
      exp_q.push_back(32'hC6);
      exp_q.push_back(32'hC7);
      do_read(32'h10, 3'd4, s);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_valid", 32'(bus.avs_readdatavalid), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.avs_readdatavalid), 32'd0);
      check("mid_rst_data", bus.avs_readdata, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", 32'(bus.avs_readdatavalid), 32'd0);
      exp_q.push_back(32'hA0);
      do_read(32'h0, 3'd1, s);
      drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
